// File: rtl/ps2_keyboard_receiver_pkg.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_receiver_pkg
// Shared definitions for the PS/2 keyboard receiver: frame FSM state
// encodings, PS/2 frame constants, scan-code prefix bytes, the payload
// struct held by the output register and a parity helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ps2_keyboard_receiver_pkg;

    // Frame FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // PS/2 frame constants
    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

    // Scan-code set 2 prefix bytes
    localparam logic [7:0] PREFIX_EXTENDED = 8'hE0;
    localparam logic [7:0] PREFIX_BREAK    = 8'hF0;

    // One entry of the holding register as seen by the consumer
    typedef struct packed {
        logic       isBreak;
        logic       isExtended;
        logic [7:0] code;
    } scanEvent_t;

    // Odd parity: data plus parity bit must hold an odd number of ones
    function automatic logic oddParityOk(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

    // True for the bytes that only qualify the following scan code
    function automatic logic isPrefixByte(input logic [7:0] data);
        return (data == PREFIX_EXTENDED) || (data == PREFIX_BREAK);
    endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_if.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_receiver_if
// Bundles the raw PS/2 lines and the scan-code valid/ack handshake.
//   iPS2_CLK, iPS2_DATA : raw PS/2 lines, asynchronous, idle high
//   iAck                : consumer accepts the held code
//   oScanCode           : held scan code
//   oValid              : oScanCode holds an unconsumed code
//   oBreak, oExtended   : qualifiers for oScanCode
//   oFrameError         : one-cycle pulse when a frame is discarded
//   oOverrun            : sticky, a completed byte was dropped
// Modports: slave = receiver side, master = keyboard/consumer side.
// ---------------------------------------------------------------------------
interface ps2_keyboard_receiver_if;

    logic       iPS2_CLK;
    logic       iPS2_DATA;
    logic       iAck;
    logic [7:0] oScanCode;
    logic       oValid;
    logic       oBreak;
    logic       oExtended;
    logic       oFrameError;
    logic       oOverrun;

    modport slave (
        input  iPS2_CLK,
        input  iPS2_DATA,
        input  iAck,
        output oScanCode,
        output oValid,
        output oBreak,
        output oExtended,
        output oFrameError,
        output oOverrun
    );

    modport master (
        output iPS2_CLK,
        output iPS2_DATA,
        output iAck,
        input  oScanCode,
        input  oValid,
        input  oBreak,
        input  oExtended,
        input  oFrameError,
        input  oOverrun
    );

endinterface

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Two-flop synchroniser followed by a FILTER_LEN-sample deglitcher for one
// PS/2 line. The filtered level only changes once FILTER_LEN consecutive
// synchronised samples agree, so a raw change appears 2 + FILTER_LEN cycles
// later and shorter glitches are ignored. Everything resets to 1 (idle).
//   Clock        : system clock
//   Reset        : asynchronous, active-high
//   rawLine      : asynchronous PS/2 line
//   filteredLine : synchronised, deglitched line
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic rawLine,
    output logic filteredLine
);

    logic [1:0]            syncStages;
    logic [FILTER_LEN-1:0] history;
    logic [FILTER_LEN-1:0] historyNext;

    // Decide on the post-shift window so the filter adds no extra cycle
    assign historyNext = FILTER_LEN'({history, syncStages[1]});

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            syncStages   <= '1;
            history      <= '1;
            filteredLine <= 1'b1;
        end else begin
            syncStages <= {syncStages[0], rawLine};
            history    <= historyNext;
            if (&historyNext) begin
                filteredLine <= 1'b1;
            end else if (historyNext == '0) begin
                filteredLine <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_receiver
// PS/2 keyboard front end for the MiniAlu datapath. Filters both PS/2 lines,
// deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop),
// abandons frames that stall for TIMEOUT_CYCLES and presents each good byte
// through a one-entry holding register with a valid/ack handshake.
//   Clock : system clock (50 MHz datapath domain)
//   Reset : asynchronous, active-high
//   bus   : ps2_keyboard_receiver_if.slave (PS/2 lines, handshake, status)
// Build option: PS2_BREAK_DECODE_EN -- when defined, E0/F0 prefixes are
// absorbed into the oExtended/oBreak qualifiers instead of being loaded.
// ---------------------------------------------------------------------------
module ps2_keyboard_receiver
    import ps2_keyboard_receiver_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input logic                     Clock,
    input logic                     Reset,
    ps2_keyboard_receiver_if.slave  bus
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned COUNT_W = $clog2(DATA_BITS);

    logic                 ps2ClkFilt;
    logic                 ps2DataFilt;
    logic                 ps2ClkPrev;
    logic                 fallEdge;

    logic [1:0]           state;
    logic [1:0]           stateNext;
    logic [COUNT_W-1:0]   bitCount;
    logic [COUNT_W-1:0]   bitCountNext;
    logic [DATA_BITS-1:0] shiftData;
    logic [DATA_BITS-1:0] shiftDataNext;
    logic                 parityBit;
    logic                 parityBitNext;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timerNext;
    logic                 byteDone;
    logic                 frameFault;

    logic                 acceptByte;
    scanEvent_t           loadEvent;
    scanEvent_t           held;
    logic                 heldValid;
    logic                 overrun;
    logic                 frameError;

    // Line conditioning
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clkFilter (
        .Clock        (Clock),
        .Reset        (Reset),
        .rawLine      (bus.iPS2_CLK),
        .filteredLine (ps2ClkFilt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dataFilter (
        .Clock        (Clock),
        .Reset        (Reset),
        .rawLine      (bus.iPS2_DATA),
        .filteredLine (ps2DataFilt)
    );

    // Falling-edge detector on the filtered PS/2 clock
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ps2ClkPrev <= 1'b1;
        end else begin
            ps2ClkPrev <= ps2ClkFilt;
        end
    end

    assign fallEdge = ps2ClkPrev & ~ps2ClkFilt;

    // Frame FSM and deserialiser state
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            bitCount  <= '0;
            shiftData <= '0;
            parityBit <= 1'b0;
            timer     <= '0;
        end else begin
            state     <= stateNext;
            bitCount  <= bitCountNext;
            shiftData <= shiftDataNext;
            parityBit <= parityBitNext;
            timer     <= timerNext;
        end
    end

    // Frame FSM next state, byte completion and fault detection
    always_comb begin
        stateNext     = state;
        bitCountNext  = bitCount;
        shiftDataNext = shiftData;
        parityBitNext = parityBit;
        timerNext     = '0;
        byteDone      = 1'b0;
        frameFault    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fallEdge) begin
                    if (ps2DataFilt == START_BIT) begin
                        stateNext    = ST_DATA;
                        bitCountNext = '0;
                    end else begin
                        frameFault = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fallEdge) begin
                    shiftDataNext = {ps2DataFilt, shiftData[DATA_BITS-1:1]};
                    bitCountNext  = bitCount + COUNT_W'(1);
                    if (bitCount == COUNT_W'(DATA_BITS - 1)) begin
                        stateNext = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fallEdge) begin
                    parityBitNext = ps2DataFilt;
                    stateNext     = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fallEdge) begin
                    if ((ps2DataFilt == STOP_BIT) && oddParityOk(shiftData, parityBit)) begin
                        byteDone = 1'b1;
                    end else begin
                        frameFault = 1'b1;
                    end
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        // Stall watchdog: restarts on every edge while a frame is open
        if (state != ST_IDLE) begin
            if (fallEdge) begin
                timerNext = '0;
            end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                stateNext  = ST_IDLE;
                frameFault = 1'b1;
                timerNext  = '0;
            end else begin
                timerNext = timer + TIMER_W'(1);
            end
        end
    end

`ifdef PS2_BREAK_DECODE_EN
    logic pendBreak;
    logic pendExtended;

    // Prefix tracking: qualifiers apply to the next non-prefix byte
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pendBreak    <= 1'b0;
            pendExtended <= 1'b0;
        end else if (frameFault) begin
            pendBreak    <= 1'b0;
            pendExtended <= 1'b0;
        end else if (byteDone) begin
            if (shiftData == PREFIX_EXTENDED) begin
                pendExtended <= 1'b1;
            end else if (shiftData == PREFIX_BREAK) begin
                pendBreak <= 1'b1;
            end else begin
                pendBreak    <= 1'b0;
                pendExtended <= 1'b0;
            end
        end
    end

    // Prefixes never reach the holding register
    always_comb begin
        acceptByte           = byteDone && !isPrefixByte(shiftData);
        loadEvent.code       = shiftData;
        loadEvent.isBreak    = pendBreak;
        loadEvent.isExtended = pendExtended;
    end
`else
    // Raw mode: every byte is loaded, qualifiers stay low
    always_comb begin
        acceptByte           = byteDone;
        loadEvent.code       = shiftData;
        loadEvent.isBreak    = 1'b0;
        loadEvent.isExtended = 1'b0;
    end
`endif

    // One-entry holding register with valid/ack handshake and status flags
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            held       <= '0;
            heldValid  <= 1'b0;
            overrun    <= 1'b0;
            frameError <= 1'b0;
        end else begin
            frameError <= frameFault;
            if (acceptByte && (!heldValid || bus.iAck)) begin
                held      <= loadEvent;
                heldValid <= 1'b1;
            end else if (acceptByte) begin
                overrun <= 1'b1;
            end else if (bus.iAck) begin
                heldValid <= 1'b0;
            end
            // An accepted ack consumes the overrun indication too
            if (bus.iAck && heldValid) begin
                overrun <= 1'b0;
            end
        end
    end

    assign bus.oScanCode   = held.code;
    assign bus.oBreak      = held.isBreak;
    assign bus.oExtended   = held.isExtended;
    assign bus.oValid      = heldValid;
    assign bus.oOverrun    = overrun;
    assign bus.oFrameError = frameError;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
`timescale 1ns/1ps
module tb_ps2_keyboard_receiver;

    localparam int unsigned FILTER_LEN     = 8;
    localparam int unsigned TIMEOUT_CYCLES = 10000;
    localparam int unsigned HALF           = 20;

    logic Clock = 1'b0;
    logic Reset;

    ps2_keyboard_receiver_if bus();

    ps2_keyboard_receiver #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;
    int errCount = 0;
    int cycleCount = 0;
    int lastFall = 0;

    always @(posedge Clock) cycleCount++;
    always @(negedge Clock) if (bus.oFrameError === 1'b1) errCount++;

    // Reference model of the consumer-visible state
    bit         mValid, mOverrun, mBrk, mExt;
    logic [7:0] mCode;
`ifdef PS2_BREAK_DECODE_EN
    bit pendBrk, pendExt;
`endif

    function automatic logic [11:0] modelWord();
        return {mValid, mOverrun, mBrk, mExt, mCode};
    endfunction

    function automatic logic [11:0] dutWord();
        return {bus.oValid, bus.oOverrun, bus.oBreak, bus.oExtended, bus.oScanCode};
    endfunction

    function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit badParity, input bit badStop);
        logic par;
        par = (~^b) ^ badParity;
        return {~badStop, par, b, 1'b0};
    endfunction

    task automatic modelReset();
        mValid = 0; mOverrun = 0; mBrk = 0; mExt = 0; mCode = 8'h00;
`ifdef PS2_BREAK_DECODE_EN
        pendBrk = 0; pendExt = 0;
`endif
    endtask

    task automatic modelFrame(input logic [7:0] b, input bit bad, input bit ackSame);
        bit brk, ext;
        if (bad) begin
`ifdef PS2_BREAK_DECODE_EN
            pendBrk = 0; pendExt = 0;
`endif
            return;
        end
`ifdef PS2_BREAK_DECODE_EN
        if (b == 8'hE0) begin pendExt = 1; return; end
        if (b == 8'hF0) begin pendBrk = 1; return; end
        brk = pendBrk; ext = pendExt;
        pendBrk = 0; pendExt = 0;
`else
        brk = 0; ext = 0;
`endif
        if (mValid && !ackSame) begin
            mOverrun = 1;
        end else begin
            if (mValid) mOverrun = 0;
            mCode = b; mValid = 1; mBrk = brk; mExt = ext;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic sendBits(input logic [10:0] bits, input int nBits, input bit ackOnLast);
        for (int i = 0; i < nBits; i++) begin
            bus.iPS2_DATA = bits[i];
            cyc(HALF / 2);
            bus.iPS2_CLK = 1'b0;
            lastFall = cycleCount;
            if (ackOnLast && i == nBits - 1) begin
                cyc(2 + FILTER_LEN);
                bus.iAck = 1'b1;
                cyc(1);
                bus.iAck = 1'b0;
                cyc(HALF - 3 - FILTER_LEN);
            end else begin
                cyc(HALF);
            end
            bus.iPS2_CLK = 1'b1;
            cyc(HALF / 2);
        end
        bus.iPS2_DATA = 1'b1;
        cyc(HALF / 2);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit badP, input bit badS, input bit ackSame);
        sendBits(makeFrame(b, badP, badS), 11, ackSame);
        cyc(4);
    endtask

    task automatic doAck();
        bus.iAck = 1'b1;
        cyc(1);
        bus.iAck = 1'b0;
        cyc(1);
        if (mValid) begin mValid = 0; mOverrun = 0; end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.iPS2_CLK = 1'b1; bus.iPS2_DATA = 1'b1; bus.iAck = 1'b0;
        modelReset();
        cyc(3);
        checks++;
        if (dutWord() !== 12'h000) begin
            failures++; $display("FAIL reset_outputs: got %0h expected 000", dutWord());
        end
        checks++;
        if (bus.oFrameError !== 1'b0) begin
            failures++; $display("FAIL reset_frame_error: got %0b expected 0", bus.oFrameError);
        end
        Reset = 1'b0;
        cyc(20);
        checks++;
        if (errCount !== 0) begin
            failures++; $display("FAIL reset_no_error: got %0d expected 0", errCount);
        end
    endtask

    task automatic test_basic();
        sendByte(8'h1C, 0, 0, 0);
        modelFrame(8'h1C, 0, 0);
        checks++;
        if (bus.oValid !== 1'b1 || bus.oScanCode !== 8'h1C) begin
            failures++; $display("FAIL basic_1C: got valid=%0b code=%0h expected valid=1 code=1c", bus.oValid, bus.oScanCode);
        end
        checks++;
        if (dutWord() !== modelWord()) begin
            failures++; $display("FAIL basic_word: got %0h expected %0h", dutWord(), modelWord());
        end
        doAck();
        checks++;
        if (bus.oValid !== 1'b0) begin
            failures++; $display("FAIL basic_ack: got valid=%0b expected 0", bus.oValid);
        end
    endtask

    task automatic test_parity_error();
        int e0;
        e0 = errCount;
        sendByte(8'h1C, 1, 0, 0);
        modelFrame(8'h1C, 1, 0);
        checks++;
        if (errCount - e0 !== 1) begin
            failures++; $display("FAIL parity_error_pulses: got %0d expected 1", errCount - e0);
        end
        checks++;
        if (dutWord() !== modelWord()) begin
            failures++; $display("FAIL parity_error_word: got %0h expected %0h", dutWord(), modelWord());
        end
    endtask

    task automatic test_start_error();
        int e0;
        e0 = errCount;
        sendBits(11'h7FF, 1, 0);
        cyc(4);
        checks++;
        if (errCount - e0 !== 1) begin
            failures++; $display("FAIL start_error_pulses: got %0d expected 1", errCount - e0);
        end
    endtask

    task automatic test_overrun();
        sendByte(8'h1C, 0, 0, 0); modelFrame(8'h1C, 0, 0);
        sendByte(8'h32, 0, 0, 0); modelFrame(8'h32, 0, 0);
        checks++;
        if (bus.oScanCode !== 8'h1C || bus.oOverrun !== 1'b1) begin
            failures++; $display("FAIL overrun_hold: got code=%0h ovr=%0b expected code=1c ovr=1", bus.oScanCode, bus.oOverrun);
        end
        checks++;
        if (dutWord() !== modelWord()) begin
            failures++; $display("FAIL overrun_word: got %0h expected %0h", dutWord(), modelWord());
        end
        doAck();
        checks++;
        if (bus.oValid !== 1'b0 || bus.oOverrun !== 1'b0) begin
            failures++; $display("FAIL overrun_ack: got valid=%0b ovr=%0b expected 0 0", bus.oValid, bus.oOverrun);
        end
    endtask

    task automatic test_ack_same_cycle();
        sendByte(8'h1C, 0, 0, 0); modelFrame(8'h1C, 0, 0);
        sendByte(8'h32, 0, 0, 1); modelFrame(8'h32, 0, 1);
        checks++;
        if (dutWord() !== modelWord()) begin
            failures++; $display("FAIL ack_same_cycle: got %0h expected %0h", dutWord(), modelWord());
        end
        doAck();
    endtask

    task automatic test_timeout();
        int e0, d;
        bit seen;
        seen = 0; d = 0;
        sendBits(makeFrame(8'h29, 0, 0), 5, 0);
        e0 = errCount;
        for (int k = 0; k < int'(TIMEOUT_CYCLES) + 100 && !seen; k++) begin
            @(negedge Clock);
            if (bus.oFrameError === 1'b1) begin
                seen = 1;
                d = cycleCount - lastFall;
            end
        end
        modelFrame(8'h00, 1, 0);
        checks++;
        if (!seen || d < int'(TIMEOUT_CYCLES) || d > int'(TIMEOUT_CYCLES + FILTER_LEN) + 8) begin
            failures++; $display("FAIL timeout_delay: got seen=%0b delay=%0d expected delay near %0d", seen, d, TIMEOUT_CYCLES);
        end
        cyc(5);
        checks++;
        if (errCount - e0 !== 1) begin
            failures++; $display("FAIL timeout_pulses: got %0d expected 1", errCount - e0);
        end
        sendByte(8'h29, 0, 0, 0); modelFrame(8'h29, 0, 0);
        checks++;
        if (dutWord() !== modelWord()) begin
            failures++; $display("FAIL timeout_recover: got %0h expected %0h", dutWord(), modelWord());
        end
        doAck();
    endtask

    task automatic test_glitch();
        int e0;
        e0 = errCount;
        bus.iPS2_CLK = 1'b0; cyc(3); bus.iPS2_CLK = 1'b1; cyc(20);
        bus.iPS2_CLK = 1'b0; cyc(FILTER_LEN - 1); bus.iPS2_CLK = 1'b1; cyc(20);
        checks++;
        if (errCount !== e0 || dutWord() !== modelWord()) begin
            failures++; $display("FAIL glitch_ignored: got err=%0d word=%0h expected err=%0d word=%0h", errCount, dutWord(), e0, modelWord());
        end
        sendByte(8'h1C, 0, 0, 0); modelFrame(8'h1C, 0, 0);
        checks++;
        if (dutWord() !== modelWord() || errCount !== e0) begin
            failures++; $display("FAIL glitch_then_frame: got %0h expected %0h", dutWord(), modelWord());
        end
        doAck();
    endtask

    task automatic test_prefix();
        sendByte(8'hF0, 0, 0, 0); modelFrame(8'hF0, 0, 0);
        checks++;
        if (dutWord() !== modelWord()) begin
            failures++; $display("FAIL prefix_F0: got %0h expected %0h", dutWord(), modelWord());
        end
`ifndef PS2_BREAK_DECODE_EN
        doAck();
`endif
        sendByte(8'h1C, 0, 0, 0); modelFrame(8'h1C, 0, 0);
        checks++;
        if (dutWord() !== modelWord()) begin
            failures++; $display("FAIL prefix_1C: got %0h expected %0h", dutWord(), modelWord());
        end
        doAck();
        sendByte(8'hE0, 0, 0, 0); modelFrame(8'hE0, 0, 0);
`ifndef PS2_BREAK_DECODE_EN
        doAck();
`endif
        sendByte(8'hF0, 0, 0, 0); modelFrame(8'hF0, 0, 0);
`ifndef PS2_BREAK_DECODE_EN
        doAck();
`endif
        sendByte(8'h75, 0, 0, 0); modelFrame(8'h75, 0, 0);
        checks++;
        if (dutWord() !== modelWord()) begin
            failures++; $display("FAIL prefix_E0F075: got %0h expected %0h", dutWord(), modelWord());
        end
        doAck();
    endtask

    task automatic test_random();
        int e0, sel, kind;
        logic [7:0] b;
        bit bp, bs;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) doAck();
            sel = $urandom_range(0, 7);
            b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
            kind = $urandom_range(0, 5);
            bp = (kind == 0);
            bs = (kind == 1);
            e0 = errCount;
            sendByte(b, bp, bs, 0);
            modelFrame(b, bp || bs, 0);
            checks++;
            if (errCount - e0 !== int'(bp || bs)) begin
                failures++; $display("FAIL random_err[%0d] byte=%0h: got %0d expected %0d", n, b, errCount - e0, int'(bp || bs));
            end
            checks++;
            if (dutWord() !== modelWord()) begin
                failures++; $display("FAIL random_word[%0d] byte=%0h: got %0h expected %0h", n, b, dutWord(), modelWord());
            end
        end
        doAck();
    endtask

    task automatic test_reset_midframe();
        int e0;
        sendByte(8'h1C, 0, 0, 0); modelFrame(8'h1C, 0, 0);
        sendBits(makeFrame(8'h55, 0, 0), 5, 0);
        e0 = errCount;
        Reset = 1'b1;
        cyc(2);
        modelReset();
        checks++;
        if (dutWord() !== 12'h000) begin
            failures++; $display("FAIL midframe_reset_outputs: got %0h expected 000", dutWord());
        end
        Reset = 1'b0;
        cyc(int'(TIMEOUT_CYCLES) / 50);
        checks++;
        if (errCount !== e0) begin
            failures++; $display("FAIL midframe_reset_no_error: got %0d expected %0d", errCount, e0);
        end
        sendByte(8'h55, 0, 0, 0); modelFrame(8'h55, 0, 0);
        checks++;
        if (dutWord() !== modelWord()) begin
            failures++; $display("FAIL midframe_reset_recover: got %0h expected %0h", dutWord(), modelWord());
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity_error();
        test_start_error();
        test_overrun();
        test_ack_same_cycle();
        test_timeout();
        test_glitch();
        test_prefix();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
